// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM types: data word, RAM handshake state, arbiter state
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arbstate_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and RAM-side signals of the memory arbiter
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      derr;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  // master: the arbiter itself; slave: the caches plus the RAM around it
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, derr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, derr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D request arbiter onto one RAM port, data priority with bounded I starvation; MEM_ARBITER_STATS_EN adds counters
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic CLK,
  input  logic nRST,
  mem_arbiter_if.master bus
`ifdef MEM_ARBITER_STATS_EN
  ,
  output word_t icnt,
  output word_t dcnt,
  output word_t stallcnt
`endif
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arbstate_t        state, next_state;
  logic [CNT_W-1:0] starve, next_starve;
  logic             dreq;

  assign dreq = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= next_state;
      starve <= next_starve;
    end
  end

  // RAM and cache outputs are decoded from the registered owner, so an async
  // reset drops ramWEN at once and no half-finished write survives.
  always_comb begin
    next_state   = state;
    next_starve  = starve;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.derr     = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state)
      IDLE: begin
        if (dreq && !(bus.iREN && starve == STARVE_LIM)) begin
          next_state = DGNT;
        end else if (bus.iREN) begin
          next_state = IGNT;
        end
      end

      DGNT: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!dreq) begin
          next_state = IDLE;
        end else if (bus.ramstate == ERROR) begin
          bus.derr   = 1'b1;
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait  = 1'b0;
          bus.dload  = bus.ramload;
          next_state = IDLE;
          if (!bus.iREN) begin
            next_starve = '0;
          end else if (starve != STARVE_LIM) begin
            next_starve = starve + 1'b1;
          end
        end
      end

      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN || bus.ramstate == ERROR) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.iwait   = 1'b0;
          bus.iload   = bus.ramload;
          next_starve = '0;
          next_state  = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

`ifdef MEM_ARBITER_STATS_EN
  // wait=0 is only ever seen by the owner in its completing cycle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt     <= '0;
      dcnt     <= '0;
      stallcnt <= '0;
    end else begin
      if (!bus.iwait) icnt <= icnt + 32'd1;
      if (!bus.dwait) dcnt <= dcnt + 32'd1;
      if ((bus.iREN && bus.iwait) || (dreq && bus.dwait)) begin
        stallcnt <= stallcnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter against a RAM model and shadow memory
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int STARVE_MAX = 4;

  logic CLK;
  logic nRST;
  mem_arbiter_if bus();

`ifdef MEM_ARBITER_STATS_EN
  word_t icnt, dcnt, stallcnt;
`endif

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .icnt     (icnt),
    .dcnt     (dcnt),
    .stallcnt (stallcnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int    n_tests;
  int    n_fail;
  int    lat;
  logic  force_err;
  int    ram_cnt;
  int    stall_model;
  word_t ram_mem [0:1023];
  word_t ref_mem [0:1023];

  function automatic word_t init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // Variable-latency RAM: BUSY for lat+1 cycles of a held request, then ACCESS
  initial for (int i = 0; i < 1024; i++) ram_mem[i] <= init_word(i);
  initial ram_cnt = 0;

  always @(posedge CLK) begin
    if (bus.ramREN || bus.ramWEN) ram_cnt <= ram_cnt + 1;
    else                          ram_cnt <= 0;
    if (bus.ramWEN && bus.ramstate == ACCESS) ram_mem[bus.ramaddr[9:0]] <= bus.ramstore;
  end

  assign bus.ramstate = force_err ? ERROR :
                        !(bus.ramREN || bus.ramWEN) ? FREE :
                        (ram_cnt > lat) ? ACCESS : BUSY;
  assign bus.ramload  = ram_mem[bus.ramaddr[9:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_i(input string tag);
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (!bus.iwait) return;
    end
    chk({tag, "_timeout"}, 32'(bus.iwait), 0);
  endtask

  task automatic wait_d(input string tag);
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (!bus.dwait) return;
    end
    chk({tag, "_timeout"}, 32'(bus.dwait), 0);
  endtask

  // Random I/D traffic; checks data against the shadow memory, single ownership,
  // idle outputs and the starvation bound at transaction level.
  task automatic run_traffic(input int cycles, input int i_quota, input int d_quota);
    int i_iss = 0, d_iss = 0, iage = 0, dage = 0, streak = 0;
    bit i_done, d_done, wr;
    to_drive();
    for (int c = 0; c < cycles + 400; c++) begin
      if (!bus.iREN && !bus.dREN && !bus.dWEN &&
          (c >= cycles || (i_iss >= i_quota && d_iss >= d_quota))) break;
      @(negedge CLK);
      i_done = bus.iREN && !bus.iwait;
      d_done = (bus.dREN || bus.dWEN) && !bus.dwait;
      if ((bus.iREN && bus.iwait) || ((bus.dREN || bus.dWEN) && bus.dwait)) stall_model++;
      chk("one_owner", 32'(bus.iwait | bus.dwait), 1);
      chk("derr_quiet", 32'(bus.derr), 0);
      if (bus.iwait) chk("iload_zero", bus.iload, 0);
      if (bus.dwait) chk("dload_zero", bus.dload, 0);
      if (i_done) begin
        chk("iload", bus.iload, ref_mem[bus.iaddr[9:0]]);
        streak = 0;
      end else if (bus.iREN) begin
        iage++;
        if (iage > 150) chk("i_timeout", 32'(bus.iwait), 0);
      end
      if (!bus.iREN) streak = 0;
      if (d_done) begin
        if (bus.dWEN) ref_mem[bus.daddr[9:0]] = bus.dstore;
        else          chk("dload", bus.dload, ref_mem[bus.daddr[9:0]]);
        if (bus.iREN) begin
          streak++;
          chk("starve_bound", 32'(streak <= STARVE_MAX), 1);
        end
      end else if (bus.dREN || bus.dWEN) begin
        dage++;
        if (dage > 150) chk("d_timeout", 32'(bus.dwait), 0);
      end
      to_drive();
      if (i_done || iage > 150) begin bus.iREN = 1'b0; iage = 0; end
      if (d_done || dage > 150) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; dage = 0; end
      if (!bus.iREN && c < cycles && i_iss < i_quota && $urandom_range(0, 2) == 0) begin
        bus.iREN  = 1'b1;
        bus.iaddr = 32'($urandom_range(0, 1023));
        i_iss++;
      end
      if (!bus.dREN && !bus.dWEN && c < cycles && d_iss < d_quota && $urandom_range(0, 2) == 0) begin
        wr         = 1'($urandom_range(0, 1));
        bus.dREN   = !wr;
        bus.dWEN   = wr;
        bus.daddr  = 32'($urandom_range(0, 1023));
        bus.dstore = $urandom;
        d_iss++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ord[$];
    int exp_ord[7];
    int d_left;
    int diffs;
    bit dd, id;

    n_tests = 0; n_fail = 0; lat = 0; force_err = 1'b0; stall_model = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h10; bus.dREN = 1'b1; bus.dWEN = 1'b0;
    bus.daddr = 32'h80; bus.dstore = '0;

    // reset with both requests pending, then D wins the first grant
    repeat (2) @(negedge CLK);
    chk("rst_iwait", 32'(bus.iwait), 1);
    chk("rst_dwait", 32'(bus.dwait), 1);
    chk("rst_ramREN", 32'(bus.ramREN), 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_iload", bus.iload, 0);
    chk("rst_dload", bus.dload, 0);
    chk("rst_derr", 32'(bus.derr), 0);
    nRST = 1'b1;
    @(negedge CLK);
    chk("rel_ramREN", 32'(bus.ramREN), 1);
    chk("rel_ramaddr", bus.ramaddr, 32'h80);
    chk("rel_iwait", 32'(bus.iwait), 1);
    wait_d("rel_d");
    chk("rel_dload", bus.dload, ref_mem[32'h80]);
    to_drive();
    bus.dREN = 1'b0;
    wait_i("rel_i");
    chk("rel_iload", bus.iload, ref_mem[32'h10]);
    to_drive();
    bus.iREN = 1'b0;
    repeat (2) to_drive();

    // I-only read, LAT=0: one BUSY cycle, then ACCESS, then a forced IDLE bubble
    bus.iREN = 1'b1; bus.iaddr = 32'h40; lat = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("i_busy_iwait", 32'(bus.iwait), 1);
    chk("i_busy_addr", bus.ramaddr, 32'h40);
    chk("i_busy_state", 32'(bus.ramstate), 32'(BUSY));
    @(negedge CLK);
    chk("i_acc_iwait", 32'(bus.iwait), 0);
    chk("i_acc_iload", bus.iload, ref_mem[32'h40]);
    @(negedge CLK);
    chk("i_bubble_iwait", 32'(bus.iwait), 1);
    chk("i_bubble_ramREN", 32'(bus.ramREN), 0);
    chk("i_bubble_iload", bus.iload, 0);
    to_drive();
    bus.iREN = 1'b0;
    @(negedge CLK);
    chk("i_withdraw_iwait", 32'(bus.iwait), 1);
    @(negedge CLK);
    chk("i_withdraw_idle", 32'(bus.ramREN), 0);

    // simultaneous I read and D write: D first, I after the bubble
    to_drive();
    lat = 1;
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    @(negedge CLK);
    @(negedge CLK);
    chk("sim_ramWEN", 32'(bus.ramWEN), 1);
    chk("sim_ramaddr", bus.ramaddr, 32'h100);
    chk("sim_ramstore", bus.ramstore, 32'hDEADBEEF);
    wait_d("sim_d");
    chk("sim_iwait_nonowner", 32'(bus.iwait), 1);
    ref_mem[32'h100] = 32'hDEADBEEF;
    to_drive();
    bus.dWEN = 1'b0;
    @(negedge CLK);
    chk("sim_written", ram_mem[32'h100], 32'hDEADBEEF);
    chk("sim_bubble", 32'(bus.ramREN), 0);
    wait_i("sim_i");
    chk("sim_iload", bus.iload, ref_mem[32'h44]);
    to_drive();
    bus.iREN = 1'b0;
    repeat (2) to_drive();

    // starvation: 6 back-to-back D loads against a held I read
    lat = 0; d_left = 6;
    bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.dREN = 1'b1; bus.daddr = 32'h200;
    for (int k = 0; k < 200 && (d_left > 0 || bus.iREN); k++) begin
      @(negedge CLK);
      dd = bus.dREN && !bus.dwait;
      id = bus.iREN && !bus.iwait;
      if (dd) begin
        ord.push_back(0);
        chk("stv_dload", bus.dload, ref_mem[bus.daddr[9:0]]);
        d_left--;
      end
      if (id) begin
        ord.push_back(1);
        chk("stv_iload", bus.iload, ref_mem[32'h48]);
      end
      to_drive();
      if (dd) begin
        if (d_left == 0) bus.dREN = 1'b0;
        else             bus.daddr = bus.daddr + 32'd1;
      end
      if (id) bus.iREN = 1'b0;
    end
    exp_ord = '{0, 0, 0, 0, 1, 0, 0};
    chk("stv_len", 32'(ord.size()), 7);
    for (int i = 0; i < 7 && i < ord.size(); i++)
      chk($sformatf("stv_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));

    // ERROR during DGNT: derr pulse, no ack, then retried
    to_drive();
    lat = 3;
    bus.dREN = 1'b1; bus.daddr = 32'h20;
    @(negedge CLK);
    @(negedge CLK);
    to_drive();
    force_err = 1'b1;
    @(negedge CLK);
    chk("derr_pulse", 32'(bus.derr), 1);
    chk("derr_dwait", 32'(bus.dwait), 1);
    chk("derr_dload", bus.dload, 0);
    to_drive();
    force_err = 1'b0;
    @(negedge CLK);
    chk("derr_clear", 32'(bus.derr), 0);
    chk("derr_idle", 32'(bus.ramREN), 0);
    wait_d("derr_retry");
    chk("derr_retry_dload", bus.dload, ref_mem[32'h20]);
    to_drive();
    bus.dREN = 1'b0;

    // ERROR during IGNT: no derr, I retried
    to_drive();
    bus.iREN = 1'b1; bus.iaddr = 32'h24;
    @(negedge CLK);
    @(negedge CLK);
    to_drive();
    force_err = 1'b1;
    @(negedge CLK);
    chk("ierr_derr", 32'(bus.derr), 0);
    chk("ierr_iwait", 32'(bus.iwait), 1);
    to_drive();
    force_err = 1'b0;
    @(negedge CLK);
    chk("ierr_idle", 32'(bus.ramREN), 0);
    wait_i("ierr_retry");
    chk("ierr_retry_iload", bus.iload, ref_mem[32'h24]);
    to_drive();
    bus.iREN = 1'b0;

    // D request withdrawn mid-grant
    to_drive();
    lat = 5;
    bus.dREN = 1'b1; bus.daddr = 32'h50;
    @(negedge CLK);
    @(negedge CLK);
    chk("wd_granted", 32'(bus.ramREN), 1);
    to_drive();
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk("wd_dwait", 32'(bus.dwait), 1);
    @(negedge CLK);
    chk("wd_idle_addr", bus.ramaddr, 0);

    // reset asserted in the middle of a write
    to_drive();
    lat = 4;
    bus.dWEN = 1'b1; bus.daddr = 32'h30; bus.dstore = 32'h12345678;
    @(negedge CLK);
    @(negedge CLK);
    chk("rmw_ramWEN_before", 32'(bus.ramWEN), 1);
    #2 nRST = 1'b0;
    #1;
    chk("rmw_ramWEN_after", 32'(bus.ramWEN), 0);
    chk("rmw_ramaddr", bus.ramaddr, 0);
    chk("rmw_dwait", 32'(bus.dwait), 1);
    repeat (3) @(negedge CLK);
    to_drive();
    bus.dWEN = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    chk("rmw_no_commit", ram_mem[32'h30], ref_mem[32'h30]);

    // randomized traffic across several RAM latencies
    for (int p = 0; p < 4; p++) begin
      lat = $urandom_range(0, 3);
      run_traffic(600, 1000, 1000);
    end
    @(negedge CLK);
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (ram_mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 32'(diffs), 0);

`ifdef MEM_ARBITER_STATS_EN
    to_drive();
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    @(negedge CLK);
    chk("stats_rst_icnt", icnt, 0);
    chk("stats_rst_stall", stallcnt, 0);
    nRST = 1'b1;
    stall_model = 0;
    lat = 2;
    run_traffic(500, 3, 2);
    @(negedge CLK);
    chk("stats_icnt", icnt, 3);
    chk("stats_dcnt", dcnt, 2);
    chk("stats_stallcnt", stallcnt, 32'(stall_model));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
